// File: rtl/gather_packet_arbiter.sv
// Packet-level round-robin merge of N_IN AXI-Stream inputs onto one registered output.
// The grant is held until TLAST is accepted; a one-cycle notify reports source and beat count.
module gather_packet_arbiter #(
  parameter int N_IN = 4,
  parameter int BW   = 32,
  parameter int BWB  = 4
) (
  input  logic                clk_line,
  input  logic                rst,
  input  logic [N_IN-1:0]     stream_in_packet_TVALID,
  input  logic [BW*N_IN-1:0]  stream_in_packet_TDATA,
  input  logic [BWB*N_IN-1:0] stream_in_packet_TKEEP,
  input  logic [N_IN-1:0]     stream_in_packet_TLAST,
  output logic [N_IN-1:0]     stream_in_packet_TREADY,
  output logic                stream_out_packet_TVALID,
  output logic [BW-1:0]       stream_out_packet_TDATA,
  output logic [BWB-1:0]      stream_out_packet_TKEEP,
  output logic                stream_out_packet_TLAST,
  input  logic                stream_out_packet_TREADY,
  output logic                notify_out_metadata_out_VALID,
  output logic [127:0]        notify_out_metadata_out_DATA
);
  localparam int GW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, r_last_grant, w_pick, w_idx;
  logic [15:0]     r_beat_cnt, w_cnt_inc;
  logic            w_any, w_vld_g, w_last_g, w_slot_free, w_accept;
  logic [BW-1:0]   w_data_g;
  logic [BWB-1:0]  w_keep_g;
  logic            r_out_valid, r_out_last;
  logic [BW-1:0]   r_out_data;
  logic [BWB-1:0]  r_out_keep;
  logic            r_nv;
  logic [127:0]    r_nd;

  // Scan from far to near so the requester closest after last_grant wins.
  always_comb begin
    w_pick = r_last_grant;
    w_idx  = '0;
    for (int k = N_IN; k >= 1; k--) begin
      w_idx = GW'((int'(r_last_grant) + k) % N_IN);
      if (stream_in_packet_TVALID[w_idx]) w_pick = w_idx;
    end
  end

  assign w_any       = |stream_in_packet_TVALID;
  assign w_vld_g     = stream_in_packet_TVALID[r_grant];
  assign w_last_g    = stream_in_packet_TLAST[r_grant];
  assign w_data_g    = stream_in_packet_TDATA[r_grant*BW +: BW];
  assign w_keep_g    = stream_in_packet_TKEEP[r_grant*BWB +: BWB];
  assign w_slot_free = !r_out_valid || stream_out_packet_TREADY;
  assign w_accept    = (r_state == XFER) && w_vld_g && w_slot_free;
  assign w_cnt_inc   = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;

  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt             = r_state;
    stream_in_packet_TREADY = '0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = XFER;
      XFER: begin
        stream_in_packet_TREADY[r_grant] = w_slot_free;
        if (w_accept && w_last_g) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= GW'(N_IN - 1);
      r_beat_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_accept) begin
        r_beat_cnt <= w_cnt_inc;
        if (w_last_g) r_last_grant <= r_grant;
      end
    end
  end

  // Output skid-free register: loads on accept, drains when downstream takes it.
  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_g;
      r_out_keep  <= w_keep_g;
      r_out_last  <= w_last_g;
    end else if (stream_out_packet_TREADY) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      r_nv <= 1'b0;
      r_nd <= '0;
    end else begin
      r_nv <= w_accept && w_last_g;
      if (w_accept && w_last_g) r_nd <= {104'd0, 8'(r_grant), w_cnt_inc};
    end
  end

  assign stream_out_packet_TVALID      = r_out_valid;
  assign stream_out_packet_TDATA       = r_out_data;
  assign stream_out_packet_TKEEP       = r_out_keep;
  assign stream_out_packet_TLAST       = r_out_last;
  assign notify_out_metadata_out_VALID = r_nv;
  assign notify_out_metadata_out_DATA  = r_nd;
endmodule

// File: doc/gather_packet_arbiter.md
Name: gather_packet_arbiter

Overview:
- Packet-level round-robin arbiter that merges N_IN tile-column AXI-Stream inputs onto one AXI-Stream output.
- Sits between the last tile column and the downstream egress, in place of a free-running packet-count mux.
- Holds its grant for a whole packet (until TLAST is accepted) and honours TREADY backpressure end to end.
- Emits a one-cycle completion notify per packet, carrying the source index and beat count.

Parameters:
- N_IN, 4, number of input streams (>=1).
- BW, 32, TDATA width per stream, in bits.
- BWB, 4, TKEEP width per stream (BW/8).
- GW, $clog2(N_IN) with a minimum of 1, grant index width (localparam).

Ports:
- clk_line  input  1  line clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- stream_in_packet_TVALID  input  N_IN  per-input valid.
- stream_in_packet_TDATA  input  BW*N_IN  input i occupies bits [BW*(i+1)-1:BW*i].
- stream_in_packet_TKEEP  input  BWB*N_IN  input i occupies bits [BWB*(i+1)-1:BWB*i].
- stream_in_packet_TLAST  input  N_IN  per-input last beat.
- stream_in_packet_TREADY  output  N_IN  per-input ready.
- stream_out_packet_TVALID  output  1  merged stream valid (registered).
- stream_out_packet_TDATA  output  BW  merged data (registered).
- stream_out_packet_TKEEP  output  BWB  merged keep (registered).
- stream_out_packet_TLAST  output  1  merged last (registered).
- stream_out_packet_TREADY  input  1  downstream ready.
- notify_out_metadata_out_VALID  output  1  one-cycle packet-complete pulse.
- notify_out_metadata_out_DATA  output  128  completion metadata.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, last_grant=N_IN-1 (so input 0 wins first), beat_cnt=0.
- Reset values of outputs: all out_* = 0, all in_TREADY = 0, notify VALID = 0, notify DATA = 0.
- Reset mid-packet discards the in-flight beat and output register content; no notify is issued.
- FSM state IDLE:
  - All in_TREADY = 0.
  - If any TVALID is set, pick the first set TVALID scanning from (last_grant+1) mod N_IN upward, wrapping.
  - Register that index as grant, clear beat_cnt, go to XFER.
  - Arbitration costs exactly one bubble cycle per packet.
- FSM state XFER:
  - slot_free = !out_TVALID || out_TREADY.
  - in_TREADY[grant] = slot_free (combinational); all other in_TREADY = 0.
  - A beat is accepted when TVALID[grant] && TREADY[grant].
  - Accepted beat: its TDATA, TKEEP and TLAST load into the output register and out_TVALID=1 on the next edge. Latency input to output is 1 cycle.
  - Accepted beat: beat_cnt increments, saturating at 16'hFFFF.
- Output register:
  - If no beat is loaded and out_TREADY=1, out_TVALID clears.
  - When out_TVALID=1, data is held stable until out_TREADY.
  - Full throughput: one beat per cycle while out_TREADY stays high.
- Packet end:
  - Accepted beat with TLAST=1: next state IDLE, last_grant <= grant.
  - Notify VALID pulses for exactly one cycle on the next edge.
  - DATA[15:0] = beat count including the last beat (saturated).
  - DATA[23:16] = grant, zero-extended.
  - DATA[127:24] = 0.
  - Notify DATA holds its value until the next pulse.
- The grant is never revoked mid-packet. Granted TVALID dropping mid-packet only stalls; other inputs wait.
- Simultaneous requests are served in round-robin order. A requester is skipped if its TVALID is low at arbitration time.
- Single-beat packets (TLAST on the first beat) are legal and produce count = 1.
- N_IN=1: grant is always 0, and the IDLE bubble is retained.

Test Plan:
- All 4 inputs hold 3-beat packets continuously, out_TREADY=1 -> output packet order 0,1,2,3,0. Notify counts are all 3 with src 0..3. One idle cycle between packets.
- Input 2 only, packet 0xA0..0xA4 (5 beats), out_TREADY toggling 1,0,1,0 -> all 5 beats appear in order with none duplicated or lost. in_TREADY[2] is low whenever out_TVALID=1 && out_TREADY=0. Notify DATA = 0x0002_0005.
- Input 1 sends 1-beat packets back to back while input 3 waits -> grants alternate 1,3,1,3. Each notify count = 1.
- Input 0 mid-packet drops TVALID for 4 cycles while input 1 is valid -> input 1 TREADY stays 0. Input 0 packet completes before any input-1 beat is output.
- Assert rst during beat 2 of a 4-beat packet -> all outputs 0 in the same cycle (asynchronous). No notify. After release, input 0 is granted first.
- Packet of 70000 beats -> notify count saturates at 0xFFFF.
